// File: rtl/mouse_event_queue_pkg.sv
// Shared field positions and entry layout for the mouse event queue.
// The mouse status word, CPU read word and queued entry all share these definitions.
package mouse_pkg;
  localparam int MS_W     = 28;
  localparam int RUN_BIT  = 27;
  localparam int BTNS_HI  = 26;
  localparam int BTNS_LO  = 24;
  localparam int Y_HI     = 21;
  localparam int Y_LO     = 12;
  localparam int X_HI     = 9;
  localparam int X_LO     = 0;

  localparam int DOUT_W    = 32;
  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;
  localparam int BCHG_BIT  = 20;

  localparam int SNAP_W  = 23;
  localparam int ENTRY_W = 24;

  typedef struct packed {
    logic [2:0] btns;
    logic [9:0] y;
    logic [9:0] x;
    logic       bchg;
  } entry_t;

  // {btns, y, x} view of a status word; the zero padding bits are dropped.
  function automatic logic [SNAP_W-1:0] snap(input logic [MS_W-1:0] ms);
    return {ms[BTNS_HI:BTNS_LO], ms[Y_HI:Y_LO], ms[X_HI:X_LO]};
  endfunction
endpackage

// File: rtl/mouse_event_queue_if.sv
// CPU/mouse-side signal bundle of the mouse event queue.
// rd is a one-cycle strobe with no ready: a strobe on a non-empty queue always pops the head.
interface mouse_event_queue_if #(parameter int DEPTH = 8);
  import mouse_pkg::*;

  logic [MS_W-1:0]          ms;
  logic                     rd;
  logic [DOUT_W-1:0]        dout;
  logic                     empty;
  logic [$clog2(DEPTH):0]   dbg_count;

  modport master (output ms, rd, input dout, empty, dbg_count);
  modport slave  (input ms, rd, output dout, empty, dbg_count);
endinterface

// File: rtl/mouse_event_queue_evt_fifo.sv
// Synchronous event FIFO with push, pop and an in-place overwrite of the newest entry.
// Callers never assert push and tail_wr together, nor pop while empty.
module evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       tail_wr_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               head_o,
  output logic [W-1:0]               tail_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] tail_idx;

  always_comb begin
    tail_idx = wr_ptr_q - AW'(1);
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + (AW+1)'(1);
    else if (!push_i && pop_i) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_i)         mem_q[wr_ptr_q] <= wdata_i;
    else if (tail_wr_i) mem_q[tail_idx] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = mem_q[tail_idx];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/mouse_event_queue.sv
// Turns PS/2 mouse status changes into queued CPU events, merging runs of pure motion.
// Holds the last-seen snapshot, the coalesce/stall decision, sticky overflow and the read mux.
module mouse_event_queue
  import mouse_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mouse_event_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SNAP_W-1:0] last_q, last_d, cur;
  logic              ovf_q, ovf_d;
  entry_t            head, tail, new_e;
  logic [CW-1:0]     count;
  logic              full, fifo_empty;
  logic              run, change, bchg, tail_free, coalesce;
  logic              push, pop, stall;
  logic              unused_bits;

  always_comb begin
    cur       = snap(bus.ms);
    run       = bus.ms[RUN_BIT];
    change    = run && (cur != last_q);
    bchg      = (cur[SNAP_W-1 -: 3] != last_q[SNAP_W-1 -: 3]);
    new_e     = '{btns: cur[22:20], y: cur[19:10], x: cur[9:0], bchg: bchg};
    pop       = bus.rd && !fifo_empty;
    // The tail may only be merged into when it is not leaving this cycle.
    tail_free = (count >= CW'(2)) || ((count == CW'(1)) && !bus.rd);
    coalesce  = change && !bchg && tail_free && !tail.bchg && (tail.btns == new_e.btns);
    push      = change && !coalesce && (!full || pop);
    stall     = change && !coalesce && full && !pop;

    last_d = last_q;
    if (!run || push || coalesce) last_d = cur;

    ovf_d = ovf_q;
    if (bus.rd) ovf_d = 1'b0;
    if (stall)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  evt_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .tail_wr_i (coalesce),
    .wdata_i   (new_e),
    .head_o    (head),
    .tail_o    (tail),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (fifo_empty)
  );

  // Empty queue shows the live mouse state so polling software still works.
  always_comb begin
    if (!fifo_empty)
      bus.dout = {1'b1, ovf_q, 3'b000, head.btns, 3'b000, head.bchg, head.y, head.x};
    else
      bus.dout = {1'b0, ovf_q, 3'b000, bus.ms[BTNS_HI:BTNS_LO], 3'b000, 1'b0,
                  bus.ms[Y_HI:Y_LO], bus.ms[X_HI:X_LO]};
  end

  assign bus.empty     = fifo_empty;
  assign bus.dbg_count = count;
  assign unused_bits   = ^{bus.ms[23:22], bus.ms[11:10], tail.y, tail.x};
endmodule

// File: tb/tb_mouse_event_queue.sv
// Bench for mouse_event_queue: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the event rules.
module tb_mouse_event_queue;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mouse_event_queue_if #(.DEPTH(DEPTH)) bus ();

  mouse_event_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: entries are {btns[2:0], y[9:0], x[9:0], bchg}
  logic [23:0] exp_q[$];
  logic [22:0] m_last;
  logic        m_ovf;
  logic        model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input logic run, input logic [2:0] b,
                                     input logic [9:0] y, input logic [9:0] x);
    return {run, b, 2'b00, y, 2'b00, x};
  endfunction

  function automatic logic [31:0] model_dout(input logic [27:0] ms);
    logic [23:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      return {1'b1, m_ovf, 3'b000, e[23:21], 3'b000, e[0], e[20:11], e[10:1]};
    end
    return {1'b0, m_ovf, 3'b000, ms[26:24], 3'b000, 1'b0, ms[21:12], ms[9:0]};
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic r, input logic [27:0] ms, input logic rd);
    logic [22:0] cur;
    logic        b_changed, popping, push_new, merge;
    int          n;
    if (r) begin
      exp_q.delete();
      m_last = '0;
      m_ovf = 1'b0;
      model_valid = 1'b1;
      return;
    end
    cur = {ms[26:24], ms[21:12], ms[9:0]};
    n = exp_q.size();
    popping = rd && (n > 0);
    push_new = 1'b0;
    b_changed = (cur[22:20] != m_last[22:20]);
    if (!ms[27]) begin
      m_last = cur;
    end else if (cur != m_last) begin
      merge = 1'b0;
      if (!b_changed && n > 0 && !(n == 1 && rd))
        merge = (exp_q[n-1][0] == 1'b0) && (exp_q[n-1][23:21] == cur[22:20]);
      if (merge) begin
        exp_q[n-1] = {cur, 1'b0};
        m_last = cur;
      end else if (n < DEPTH || popping) begin
        push_new = 1'b1;
        m_last = cur;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (rd && !(ms[27] && cur != m_last && n == DEPTH && !popping)) m_ovf = 1'b0;
    if (popping) void'(exp_q.pop_front());
    if (push_new) exp_q.push_back({cur, b_changed});
  endtask

  // Compare on the falling edge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("dout", bus.dout, model_dout(bus.ms));
      chk("empty", {31'b0, bus.empty}, {31'b0, exp_q.size() == 0});
      chk("count", {28'b0, bus.dbg_count}, exp_q.size());
    end
    model_step(rst, bus.ms, bus.rd);
  end

  // driver
  task automatic apply(input logic [27:0] ms, input logic rd);
    bus.ms = ms;
    bus.rd = rd;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rb;
  logic [9:0] rx, ry;

  initial begin
    rst = 1'b1;
    bus.ms = '0;
    bus.rd = 1'b0;
    apply(28'h0, 1'b0);
    apply(28'h0, 1'b0);
    chk("rst_empty", {31'b0, bus.empty}, 32'd1);
    chk("rst_count", {28'b0, bus.dbg_count}, 32'd0);
    chk("rst_dout_hi", {30'b0, bus.dout[31:30]}, 32'd0);
    chk("rst_bchg", {31'b0, bus.dout[20]}, 32'd0);
    rst = 1'b0;

    // single event then read back to live view
    apply(mk(1'b1, 3'd0, 10'd0, 10'd5), 1'b0);
    chk("first_evt", bus.dout, 32'h8000_0005);
    chk("first_cnt", {28'b0, bus.dbg_count}, 32'd1);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd5), 1'b1);
    chk("live_view", bus.dout, 32'h0000_0005);

    // motion run merges into one entry
    apply(mk(1'b1, 3'd0, 10'd0, 10'd1), 1'b0);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd2), 1'b0);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd3), 1'b0);
    chk("merge_dout", bus.dout, 32'h8000_0003);
    chk("merge_cnt", {28'b0, bus.dbg_count}, 32'd1);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd3), 1'b1);

    // press, motion, release stay separate
    apply(mk(1'b1, 3'd1, 10'd0, 10'd3), 1'b0);
    apply(mk(1'b1, 3'd1, 10'd0, 10'd4), 1'b0);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd4), 1'b0);
    chk("btn_cnt", {28'b0, bus.dbg_count}, 32'd3);
    chk("press", bus.dout, 32'h8110_0003);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd4), 1'b1);
    chk("motion", bus.dout, 32'h8100_0004);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd4), 1'b1);
    chk("release", bus.dout, 32'h8010_0004);
    apply(mk(1'b1, 3'd0, 10'd0, 10'd4), 1'b1);
    chk("drained", bus.dout, 32'h0000_0004);

    // fill, then overflow
    for (int i = 0; i < DEPTH; i++)
      apply(mk(1'b1, (i % 2 == 0) ? 3'd1 : 3'd0, 10'd0, 10'd4), 1'b0);
    chk("full_cnt", {28'b0, bus.dbg_count}, 32'd8);
    apply(mk(1'b1, 3'd1, 10'd0, 10'd4), 1'b0);
    chk("ovf_set", {31'b0, bus.dout[30]}, 32'd1);
    chk("ovf_cnt", {28'b0, bus.dbg_count}, 32'd8);
    bus.rd = 1'b1;
    #1;
    chk("ovf_on_read", {31'b0, bus.dout[30]}, 32'd1);
    @(posedge clk);
    #1;
    chk("ovf_cleared", {31'b0, bus.dout[30]}, 32'd0);
    chk("retry_cnt", {28'b0, bus.dbg_count}, 32'd8);
    chk("next_head", bus.dout, 32'h8010_0004);

    // full with simultaneous pop and push
    apply(mk(1'b1, 3'd2, 10'd0, 10'd4), 1'b1);
    chk("popush_cnt", {28'b0, bus.dbg_count}, 32'd8);
    chk("popush_ovf", {31'b0, bus.dout[30]}, 32'd0);

    // reset with entries queued
    for (int i = 0; i < 3; i++) apply(mk(1'b1, 3'd2, 10'd0, 10'd4), 1'b1);
    chk("pre_rst_cnt", {28'b0, bus.dbg_count}, 32'd5);
    rst = 1'b1;
    apply(mk(1'b1, 3'd2, 10'd0, 10'd4), 1'b0);
    rst = 1'b0;
    chk("mid_rst_empty", {31'b0, bus.empty}, 32'd1);
    chk("mid_rst_hi", {30'b0, bus.dout[31:30]}, 32'd0);

    // run=0 produces nothing
    for (int i = 0; i < 10; i++)
      apply(mk(1'b0, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023))), 1'b0);
    chk("norun_cnt", {28'b0, bus.dbg_count}, 32'd0);

    // random traffic
    rb = 3'd0; rx = 10'd0; ry = 10'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) rx = 10'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ry = 10'($urandom_range(0, 1));
      rst = ($urandom_range(0, 249) == 0);
      apply(mk($urandom_range(0, 9) != 0, rb, ry, rx),
            (i < 1000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0));
    end
    rst = 1'b0;
    apply(bus.ms, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
